// File: rtl/ifid_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : ifid_pipe_reg
// Description : IF/ID pipeline register with a two-entry skid buffer.
//               The main entry drives the ID-stage outputs. The skid entry
//               catches a word accepted while main is stalled. in_ready is
//               taken from registered state only, so there is no
//               combinational path from out_ready to in_ready.
//               Optional feature macro: IFID_STALL_CNT_EN enables a
//               saturating 16-bit counter of stalled ID cycles. Without the
//               macro, stall_cnt is tied to zero.
// Ports       : clk, rst (async, active-high), flush (sync)
//               in_valid/in_ready, instruc_in, addr_in    - IF side
//               out_valid/out_ready, instruc_out, addr_out - ID side
//               opcode, funct, offset - field slices of instruc_out
//               stall_cnt - count of cycles with out_valid=1, out_ready=0
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_pipe_reg #(
  parameter int INSTR_W  = 16,
  parameter int ADDR_W   = 8,
  parameter int OPCODE_W = 4,
  parameter int FUNCT_W  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTR_W-1:0]           instruc_in,
  input  logic [ADDR_W-1:0]            addr_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTR_W-1:0]           instruc_out,
  output logic [ADDR_W-1:0]            addr_out,
  output logic [OPCODE_W-1:0]          opcode,
  output logic [FUNCT_W-1:0]           funct,
  output logic [INSTR_W-OPCODE_W-1:0]  offset,
  output logic [15:0]                  stall_cnt
);

  localparam int c_OFFSET_W = INSTR_W - OPCODE_W;

  logic               r_main_valid;
  logic [INSTR_W-1:0] r_main_instr;
  logic [ADDR_W-1:0]  r_main_addr;
  logic               r_skid_valid;
  logic [INSTR_W-1:0] r_skid_instr;
  logic [ADDR_W-1:0]  r_skid_addr;

  logic w_accept;
  logic w_consume;

  // The skid entry is only ever filled while main is full, so a free skid
  // slot always means at least one slot is available for the next word.
  assign in_ready  = ~r_skid_valid;
  assign w_accept  = in_valid & ~r_skid_valid;
  assign w_consume = r_main_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_main_instr <= '0;
      r_main_addr  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= '0;
      r_skid_addr  <= '0;
    end else if (flush) begin
      // Only the valid flags drop; data registers keep their last contents.
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid || w_consume) begin
      // Main is free this edge: the older skid word has priority over input.
      // While skid is full in_ready is low, so no input can be lost here.
      if (r_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_instr <= r_skid_instr;
        r_main_addr  <= r_skid_addr;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main_valid <= 1'b1;
        r_main_instr <= instruc_in;
        r_main_addr  <= addr_in;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      // Main is stalled: park the new word in the skid entry.
      r_skid_valid <= 1'b1;
      r_skid_instr <= instruc_in;
      r_skid_addr  <= addr_in;
    end
  end

  assign out_valid   = r_main_valid;
  assign instruc_out = r_main_instr;
  assign addr_out    = r_main_addr;
  assign opcode      = r_main_instr[INSTR_W-1 -: OPCODE_W];
  assign funct       = r_main_instr[FUNCT_W-1:0];
  assign offset      = r_main_instr[c_OFFSET_W-1:0];

`ifdef IFID_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Counts ID-stage backpressure cycles; flush does not touch it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
    end else if (r_main_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifid_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifid_pipe_reg
// Description : Self-checking bench for ifid_pipe_reg. A reference model
//               treats the buffer as a two-deep FIFO: accepted words are
//               pushed into an expected queue, and a negedge monitor
//               compares the DUT against the queue head. The monitor pops
//               the head on each handshake. A second instance checks the
//               field slices at INSTR_W=32, OPCODE_W=6, FUNCT_W=6.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifid_pipe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instruc_in;
  logic [7:0]  addr_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] instruc_out;
  logic [7:0]  addr_out;
  logic [3:0]  opcode;
  logic [3:0]  funct;
  logic [11:0] offset;
  logic [15:0] stall_cnt;

  logic        in_ready2;
  logic [31:0] instruc_in2;
  logic        out_valid2;
  logic [31:0] instruc_out2;
  logic [7:0]  addr_out2;
  logic [5:0]  opcode2;
  logic [5:0]  funct2;
  logic [25:0] offset2;
  logic [15:0] stall_cnt2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ifid_pipe_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruc_in(instruc_in), .addr_in(addr_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .instruc_out(instruc_out), .addr_out(addr_out),
    .opcode(opcode), .funct(funct), .offset(offset),
    .stall_cnt(stall_cnt)
  );

  ifid_pipe_reg #(.INSTR_W(32), .ADDR_W(8), .OPCODE_W(6), .FUNCT_W(6)) dut32 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(1'b1), .in_ready(in_ready2),
    .instruc_in(instruc_in2), .addr_in(8'h5A),
    .out_valid(out_valid2), .out_ready(1'b1),
    .instruc_out(instruc_out2), .addr_out(addr_out2),
    .opcode(opcode2), .funct(funct2), .offset(offset2),
    .stall_cnt(stall_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [15:0] i;
    logic [7:0]  a;
  } ent_t;

  ent_t        exp_q[$];
  int unsigned m_stall = 0;

  always @(negedge clk) begin
    ent_t e;
    bit   acc;
    bit   con;
    if (rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_instr", instruc_out, 0);
      chk("rst_addr", addr_out, 0);
      chk("rst_fields", {opcode, funct, offset}, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      exp_q.delete();
      m_stall = 0;
    end else begin
      chk("out_valid", out_valid, exp_q.size() > 0);
      chk("in_ready", in_ready, exp_q.size() < 2);
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        chk("instr", instruc_out, e.i);
        chk("addr", addr_out, e.a);
        chk("opcode", opcode, e.i[15:12]);
        chk("funct", funct, e.i[3:0]);
        chk("offset", offset, e.i[11:0]);
      end
`ifdef IFID_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, m_stall);
`else
      chk("stall_cnt", stall_cnt, 0);
`endif
      // Inputs are stable here until after the next rising edge, so this
      // is what that edge will do.
      acc = in_valid && (exp_q.size() < 2);
      con = out_ready && (exp_q.size() > 0);
      if ((exp_q.size() > 0) && !out_ready && (m_stall < 32'hFFFF)) m_stall++;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (con) void'(exp_q.pop_front());
        if (acc) begin
          e.i = instruc_in;
          e.a = addr_in;
          exp_q.push_back(e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [15:0] i, input logic [7:0] a,
                       input logic r, input logic f);
    @(posedge clk);
    #1;
    in_valid   = v;
    instruc_in = i;
    addr_in    = a;
    out_ready  = r;
    flush      = f;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w2;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instruc_in = '0; addr_in = '0; instruc_in2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Pass-through with latency 1
    drive(1, 16'h1A23, 8'h04, 1, 0);
    drive(0, 16'h0000, 8'h00, 1, 0);
    @(negedge clk);
    chk("pt_valid", out_valid, 1);
    chk("pt_opcode", opcode, 4'h1);
    chk("pt_funct", funct, 4'h3);
    chk("pt_offset", offset, 12'hA23);
    chk("pt_addr", addr_out, 8'h04);

    // Backpressure fills main then skid; release drains in order
    drive(1, 16'h1111, 8'h10, 0, 0);
    drive(1, 16'h2222, 8'h11, 0, 0);
    drive(0, 16'h0000, 8'h00, 0, 0);
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_main", instruc_out, 16'h1111);
    drive(0, 16'h0000, 8'h00, 1, 0);
    @(negedge clk);
    chk("bp_first", instruc_out, 16'h1111);
    drive(0, 16'h0000, 8'h00, 1, 0);
    @(negedge clk);
    chk("bp_second", instruc_out, 16'h2222);
    chk("bp_second_valid", out_valid, 1);
    drive(0, 16'h0000, 8'h00, 1, 0);
    @(negedge clk);
    chk("bp_drained", out_valid, 0);

    // Flush with both entries full and a word offered
    drive(1, 16'h4444, 8'h20, 0, 0);
    drive(1, 16'h5555, 8'h21, 0, 0);
    drive(1, 16'h6666, 8'h22, 0, 1);
    drive(0, 16'h0000, 8'h00, 1, 0);
    @(negedge clk);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    drive(1, 16'h7777, 8'h23, 1, 1);
    drive(0, 16'h0000, 8'h00, 1, 0);
    @(negedge clk);
    chk("fl_offered_absent", out_valid, 0);

    // Asynchronous reset mid-cycle with skid full
    drive(1, 16'h8888, 8'h30, 0, 0);
    drive(1, 16'h9999, 8'h31, 0, 0);
    drive(0, 16'h0000, 8'h00, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_instr", instruc_out, 0);
    chk("ar_addr", addr_out, 0);
    chk("ar_fields", {opcode, funct, offset}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b1; instruc_in = 16'hABCD; addr_in = 8'h40; out_ready = 1'b1;
    @(negedge clk);
    chk("ar_pre_accept", out_valid, 0);
    drive(0, 16'h0000, 8'h00, 1, 0);
    @(negedge clk);
    chk("ar_first_accept", instruc_out, 16'hABCD);

    // Stall counter: five stalled cycles
    drive(0, 16'h0000, 8'h00, 1, 0);
    drive(1, 16'hC0DE, 8'h50, 0, 0);
    repeat (6) drive(0, 16'h0000, 8'h00, 0, 0);
    @(negedge clk);
`ifdef IFID_STALL_CNT_EN
    chk("cnt_five", stall_cnt, 16'd5);
    repeat (65540) @(posedge clk);
    @(negedge clk);
    chk("cnt_saturate", stall_cnt, 16'hFFFF);
    drive(0, 16'h0000, 8'h00, 0, 1);
    drive(0, 16'h0000, 8'h00, 1, 0);
    @(negedge clk);
    chk("cnt_flush_keeps", stall_cnt, 16'hFFFF);
`else
    chk("cnt_disabled", stall_cnt, 16'd0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      @(posedge clk);
      #1;
      rst        = ($urandom_range(99, 0) < 1);
      in_valid   = ($urandom_range(99, 0) < 70);
      out_ready  = ($urandom_range(99, 0) < 60);
      flush      = ($urandom_range(99, 0) < 5);
      instruc_in = 16'($urandom);
      addr_in    = 8'($urandom);
    end
    drive(0, 16'h0000, 8'h00, 1, 0);
    rst = 1'b0;
    repeat (3) drive(0, 16'h0000, 8'h00, 1, 0);

    // Wide parameter set: slices follow INSTR_W=32, OPCODE_W=6, FUNCT_W=6
    w2 = '0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (k > 0) begin
        chk("p32_valid", out_valid2, 1);
        chk("p32_in_ready", in_ready2, 1);
        chk("p32_instr", instruc_out2, w2);
        chk("p32_addr", addr_out2, 8'h5A);
        chk("p32_opcode", opcode2, w2[31:26]);
        chk("p32_funct", funct2, w2[5:0]);
        chk("p32_offset", offset2, w2[25:0]);
        chk("p32_stall", stall_cnt2, 0);
      end
      w2 = $urandom;
      instruc_in2 = w2;
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifid_pipe_reg.md
IFID_PIPE_REG -- requirements
Module: ifid_pipe_reg

Interface
REQ-001 SHALL have parameter INSTR_W, default 16, instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 8, instruction address width.
REQ-003 SHALL have parameter OPCODE_W, default 4, opcode field width (instr MSBs).
REQ-004 SHALL have parameter FUNCT_W, default 4, funct field width (instr LSBs).
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port flush  input  1  synchronous pipeline flush (branch/jump taken).
REQ-008 SHALL have port in_valid  input  1  IF stage presents instruction.
REQ-009 SHALL have port in_ready  output  1  buffer can accept this cycle.
REQ-010 SHALL have port instruc_in  input  INSTR_W  fetched instruction.
REQ-011 SHALL have port addr_in  input  ADDR_W  fetch address.
REQ-012 SHALL have port out_valid  output  1  ID stage content valid.
REQ-013 SHALL have port out_ready  input  1  ID stage consumes this cycle.
REQ-014 SHALL have port instruc_out  output  INSTR_W  registered instruction.
REQ-015 SHALL have port addr_out  output  ADDR_W  registered address.
REQ-016 SHALL have port opcode  output  OPCODE_W  instruc_out[INSTR_W-1 -: OPCODE_W].
REQ-017 SHALL have port funct  output  FUNCT_W  instruc_out[FUNCT_W-1:0].
REQ-018 SHALL have port offset  output  INSTR_W-OPCODE_W  instruc_out[INSTR_W-OPCODE_W-1:0].
REQ-019 SHALL have port stall_cnt  output  16  count of stalled ID cycles.

Function
REQ-020 SHALL hold two entries: main (drives outputs) and skid; each with a valid flag.
REQ-021 SHALL drive in_ready = NOT skid_valid, from registered state only (no combinational path from out_ready).
REQ-022 SHALL accept input when in_valid AND in_ready; accepted word appears on outputs with out_valid=1 the next cycle when main is empty or consumed (latency 1).
REQ-023 SHALL, on consume (out_valid AND out_ready), load main from skid if skid_valid, else from an accepted input, else clear out_valid.
REQ-024 SHALL, when main valid, not consumed, and input accepted, store input in skid (in_ready falls next cycle).
REQ-025 SHALL preserve order; no word duplicated or dropped except by flush.
REQ-026 SHALL derive opcode, funct, offset from the main entry's instruction, zero when main invalid after reset, otherwise holding last loaded value.
REQ-027 SHALL, on flush, clear main and skid valid next edge and discard any input offered that cycle; flush outranks all other events.
REQ-028 SHALL leave data registers unchanged on flush (only valid flags clear).
REQ-029 SHALL keep main contents stable while out_valid=1 and out_ready=0.

Reset
REQ-030 SHALL on rst=1 immediately clear out_valid, skid valid, instruc_out, addr_out, derived fields and stall_cnt to 0; in_ready=1.
REQ-031 SHALL abandon any in-flight entries on reset mid-operation; first accept after release occurs on the first edge with rst=0.

Configuration
REQ-032 SHALL, with IFID_STALL_CNT_EN defined, increment stall_cnt each cycle out_valid=1 AND out_ready=0, saturating at 16'hFFFF, unaffected by flush.
REQ-033 SHALL, without IFID_STALL_CNT_EN, tie stall_cnt to 0 and implement no counter logic.

Verification
REQ-034 SHALL test pass-through: out_ready=1, push 16'h1A23 @8'h04 -> next cycle out_valid=1, opcode=4'h1, funct=4'h3, offset=12'hA23, addr_out=8'h04.
REQ-035 SHALL test backpressure: out_ready=0, push 16'h1111 then 16'h2222 -> in_ready=0 after second; main=16'h1111; release -> 16'h1111 then 16'h2222, no loss.
REQ-036 SHALL test flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, offered word absent.
REQ-037 SHALL test counter (macro on): hold out_ready=0 with valid word 5 cycles -> stall_cnt=5; preload near 16'hFFFF -> stays 16'hFFFF.
REQ-038 SHALL test asynchronous reset asserted mid-clock with skid full -> outputs 0 before next edge, in_ready=1.
REQ-039 SHALL test parameter set INSTR_W=32, OPCODE_W=6, FUNCT_W=6 -> field slices match REQ-016..018.
